// File: rtl/wb_arbiter4.sv
// ============================================================================
// Module      : wb_arbiter4
// Description : Four-requester round-robin arbiter for the shared write-back
//               path. Grants the 4:1 write-back mux to one requester at a
//               time, drives the mux selects {s1,s0} with the owner index,
//               and provides a one-hot grant vector, busy and timeout flags.
//               Ownership is level-held for as long as the owner requests.
// Options     : `define WB_ARB4_WATCHDOG_EN to build the hold-time watchdog
//               (forced revoke after MAX_HOLD cycles). Without it, grant hold
//               is unlimited and timeout is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter4 #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t     r_state,   w_state_nxt;
   logic [1:0] r_last,    w_last_nxt;     // most recently granted index == owner
   logic [3:0] r_gnt,     w_gnt_nxt;
   logic [1:0] r_sel,     w_sel_nxt;
   logic       r_busy,    w_busy_nxt;
   logic       r_timeout, w_timeout_nxt;

   logic [3:0] w_mask;        // requests eligible for this edge's decision
   logic       w_win_found;
   logic [1:0] w_win_idx;
   logic       w_own_req;     // owner still requesting
   logic       w_hold_limit;  // watchdog says the owner has held long enough
   logic       w_new_grant;

   // The current owner is excluded from arbitration whenever it gives up or
   // loses the path, which also makes it lowest priority for that decision.
   assign w_own_req = req[r_last];
   assign w_mask    = (r_state == ST_OWN) ? (req & ~r_gnt) : req;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      logic [1:0] v_cand;
      w_win_found = 1'b0;
      w_win_idx   = r_last;
      for (int k = 1; k <= 4; k++) begin
         v_cand = r_last + 2'(k);
         if (!w_win_found && w_mask[v_cand]) begin
            w_win_found = 1'b1;
            w_win_idx   = v_cand;
         end
      end
   end

`ifdef WB_ARB4_WATCHDOG_EN
   logic [CNT_W-1:0] r_cnt;

   assign w_hold_limit = (r_state == ST_OWN) && (r_cnt == CNT_W'(MAX_HOLD - 1));

   // Hold counter: cleared on each new grant, counts every OWN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_new_grant) begin
         r_cnt <= '0;
      end else if (r_state == ST_OWN) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] w_unused_cfg;
   assign w_unused_cfg = CNT_W'(MAX_HOLD - 1);
   assign w_hold_limit = 1'b0;
`endif

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_last_nxt    = r_last;
      w_gnt_nxt     = r_gnt;
      w_sel_nxt     = r_sel;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      w_new_grant   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_win_found) begin
               w_new_grant = 1'b1;
            end
         end
         ST_OWN: begin
            if (!w_own_req || w_hold_limit) begin
               // Revoke only counts as a timeout if the owner still wanted it.
               w_timeout_nxt = w_own_req;
               if (w_win_found) begin
                  w_new_grant = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = 4'b0000;
                  w_busy_nxt  = 1'b0;
                  // selects keep the previous owner to avoid mux glitches
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_busy_nxt  = 1'b0;
         end
      endcase

      if (w_new_grant) begin
         w_state_nxt = ST_OWN;
         w_gnt_nxt   = 4'b0001 << w_win_idx;
         w_sel_nxt   = w_win_idx;
         w_last_nxt  = w_win_idx;
         w_busy_nxt  = 1'b1;
      end
   end

   // State and output registers; last=3 at reset so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_last    <= 2'd3;
         r_gnt     <= 4'b0000;
         r_sel     <= 2'b00;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_last    <= w_last_nxt;
         r_gnt     <= w_gnt_nxt;
         r_sel     <= w_sel_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign s1      = r_sel[1];
   assign s0      = r_sel[0];
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter4.sv
// ============================================================================
// Module      : tb_wb_arbiter4
// Description : Self-checking bench for wb_arbiter4. A vector table covers the
//               round-robin/hold/release behaviour; hand-written sequences
//               cover asynchronous reset and long holds (watchdog when
//               WB_ARB4_WATCHDOG_EN is defined, unlimited hold otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter4;

   // {gnt[3:0], sel[1:0], busy, timeout}
   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      exp_t       exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       s0;
   logic       s1;
   logic       busy;
   logic       timeout;

   int   n_checks;
   int   n_errors;
   exp_t sb[$];
   vec_t tbl[20];

   wb_arbiter4 #(.MAX_HOLD(15), .CNT_W(4)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .s0      (s0),
      .s1      (s1),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s,
                               input logic b, input logic t);
      exp_t e;
      e.gnt = g; e.sel = s; e.busy = b; e.to = t;
      return e;
   endfunction

   task automatic check(input exp_t e, input string name);
      n_checks++;
      if ({gnt, s1, s0, busy, timeout} !== e) begin
         n_errors++;
         $display("FAIL %s: got gnt=%b sel=%b%b busy=%b timeout=%b, expected gnt=%b sel=%b busy=%b timeout=%b",
                  name, gnt, s1, s0, busy, timeout, e.gnt, e.sel, e.busy, e.to);
      end
   endtask

   // Drive req on the falling edge, queue the expectation, compare after the
   // next rising edge.
   task automatic step(input logic [3:0] r, input exp_t e, input string name);
      @(negedge clk);
      req = r;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
      end else begin
         check(sb.pop_front(), name);
      end
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      check(mk(4'b0000, 2'b00, 1'b0, 1'b0), name);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      req      = 4'b0000;
      rst_n    = 1'b0;

      tbl[0]  = '{4'b0000, mk(4'b0000, 2'b00, 1'b0, 1'b0)};
      tbl[1]  = '{4'b1111, mk(4'b0001, 2'b00, 1'b1, 1'b0)};
      tbl[2]  = '{4'b1111, mk(4'b0001, 2'b00, 1'b1, 1'b0)};
      tbl[3]  = '{4'b1110, mk(4'b0010, 2'b01, 1'b1, 1'b0)};
      tbl[4]  = '{4'b1100, mk(4'b0100, 2'b10, 1'b1, 1'b0)};
      tbl[5]  = '{4'b1000, mk(4'b1000, 2'b11, 1'b1, 1'b0)};
      tbl[6]  = '{4'b0000, mk(4'b0000, 2'b11, 1'b0, 1'b0)};
      tbl[7]  = '{4'b0100, mk(4'b0100, 2'b10, 1'b1, 1'b0)};
      tbl[8]  = '{4'b0100, mk(4'b0100, 2'b10, 1'b1, 1'b0)};
      tbl[9]  = '{4'b0000, mk(4'b0000, 2'b10, 1'b0, 1'b0)};
      tbl[10] = '{4'b0010, mk(4'b0010, 2'b01, 1'b1, 1'b0)};
      tbl[11] = '{4'b1011, mk(4'b0010, 2'b01, 1'b1, 1'b0)};
      tbl[12] = '{4'b1001, mk(4'b1000, 2'b11, 1'b1, 1'b0)};
      tbl[13] = '{4'b1001, mk(4'b1000, 2'b11, 1'b1, 1'b0)};
      tbl[14] = '{4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0)};
      tbl[15] = '{4'b0011, mk(4'b0001, 2'b00, 1'b1, 1'b0)};
      tbl[16] = '{4'b0010, mk(4'b0010, 2'b01, 1'b1, 1'b0)};
      tbl[17] = '{4'b0011, mk(4'b0010, 2'b01, 1'b1, 1'b0)};
      tbl[18] = '{4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0)};
      tbl[19] = '{4'b0000, mk(4'b0000, 2'b00, 1'b0, 1'b0)};

      // Reset state
      #2;
      check(mk(4'b0000, 2'b00, 1'b0, 1'b0), "reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin / hold / release vectors
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].req, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Asynchronous reset mid-grant (last=0, so 1111 grants requester 1)
      step(4'b1111, mk(4'b0010, 2'b01, 1'b1, 1'b0), "pre_rst_grant");
      step(4'b1111, mk(4'b0010, 2'b01, 1'b1, 1'b0), "pre_rst_hold");
      #2;
      rst_n = 1'b0;
      #1;
      check(mk(4'b0000, 2'b00, 1'b0, 1'b0), "async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, mk(4'b0001, 2'b00, 1'b1, 1'b0), "post_rst_first");

      // Single requester held for a long time
      do_reset("reset_before_hold1");
      step(4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0), "hold1_grant");
`ifdef WB_ARB4_WATCHDOG_EN
      for (int i = 2; i <= 15; i++) begin
         step(4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0), $sformatf("hold1_c%0d", i));
      end
      step(4'b0001, mk(4'b0000, 2'b00, 1'b0, 1'b1), "hold1_revoke");
      step(4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0), "hold1_regrant");
`else
      for (int i = 2; i <= 30; i++) begin
         step(4'b0001, mk(4'b0001, 2'b00, 1'b1, 1'b0), $sformatf("hold1_c%0d", i));
      end
`endif

      // Stuck owner 0 with requester 1 waiting
      do_reset("reset_before_hold2");
      step(4'b0011, mk(4'b0001, 2'b00, 1'b1, 1'b0), "hold2_grant");
      for (int i = 2; i <= 15; i++) begin
         step(4'b0011, mk(4'b0001, 2'b00, 1'b1, 1'b0), $sformatf("hold2_c%0d", i));
      end
`ifdef WB_ARB4_WATCHDOG_EN
      step(4'b0011, mk(4'b0010, 2'b01, 1'b1, 1'b1), "hold2_switch");
      step(4'b0011, mk(4'b0010, 2'b01, 1'b1, 1'b0), "hold2_after");
`else
      for (int i = 16; i <= 25; i++) begin
         step(4'b0011, mk(4'b0001, 2'b00, 1'b1, 1'b0), $sformatf("hold2_c%0d", i));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL watchdog_timeout: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

endmodule

`default_nettype wire
